// File: rtl/load_store_unit.sv
// RV32I data-memory stage: one load/store at a time over a req/gnt/rvalid bus,
// with store lane steering, load alignment/extension and a bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic        reg_write,
    output logic        done,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StReq, StResp, StWb, StFault} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;

    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic [4:0]      rd_q;
    logic [31:0]     rdata_q;

    logic            accept;
    logic            illegal;
    logic            misaligned;
    logic            timeout_hit;
    logic [3:0]      wstrb_new;
    logic [31:0]     wdata_new;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [31:0]     load_fmt;

    assign accept      = req_valid && (state_q == StIdle);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    // Loads allow 000,001,010,100,101; stores allow only 000,001,010.
    always_comb begin
        if (is_store) begin
            illegal = funct3[2] || (funct3[1:0] == 2'b11);
        end else begin
            illegal = (funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        wstrb_new = 4'b1111;
        wdata_new = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb_new = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_new = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_byte = mem_rdata[7:0];
            2'b01:   lane_byte = mem_rdata[15:8];
            2'b10:   lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_fmt = {24'h0, lane_byte};
            3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_fmt = {16'h0, lane_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    // A handshake arriving in the last allowed cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (illegal || misaligned) ? StFault : StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d = is_store_q ? StWb : StResp;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d   = StIdle;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (mem_rvalid) begin
                    state_d = StWb;
                end else if (timeout_hit) begin
                    state_d   = StIdle;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWb:    state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            rd_q       <= 5'd0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                rd_q       <= rd_in;
                wstrb_q    <= is_store ? wstrb_new : 4'b0000;
                wdata_q    <= is_store ? wdata_new : 32'h0;
            end
            if ((state_q == StResp) && mem_rvalid) begin
                rdata_q <= load_fmt;
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign mem_req    = (state_q == StReq);
    assign mem_we     = is_store_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign rd         = rd_q;
    assign write_data = rdata_q;
    assign done       = (state_q == StWb);
    assign reg_write  = (state_q == StWb) && !is_store_q && (rd_q != 5'd0);
    assign misalign   = (state_q == StFault);
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit; a transaction-level model predicts
// bus fields, fault/timeout outcome and formatted load data per operation.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        reg_write;
    logic        done;
    logic        misalign;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rd(rd),
        .write_data(write_data), .reg_write(reg_write), .done(done),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Random request traffic while the unit is busy; it must be ignored.
    task automatic scramble;
        req_valid  = 1'($urandom_range(0, 1));
        is_store   = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        rd_in      = 5'($urandom);
    endtask

    function automatic logic is_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic        legal;
        int unsigned sz;
        legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        sz = 1 << (f3 % 4);
        return !legal || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned sh;
        logic [31:0] b, h;
        sh = (a % 4) * 8;
        b  = (w >> sh) & 32'hFF;
        h  = (w >> sh) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic store_lanes(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd, output logic [3:0] es,
                               output logic [31:0] ed);
        if (!st) begin
            es = 4'h0;
            ed = 32'h0;
        end else begin
            case (f3)
                3'd0: begin
                    es = 4'(1 << (a % 4));
                    ed = (sd & 32'hFF) * 32'h0101_0101;
                end
                3'd1: begin
                    es = 4'(3 << (a % 4));
                    ed = (sd & 32'hFFFF) * 32'h0001_0001;
                end
                default: begin
                    es = 4'hF;
                    ed = sd;
                end
            endcase
        end
    endtask

    task automatic expect_timeout;
        req_valid = 1'b0;
        check("tmo_bus_err", bus_err, 1'b1);
        check("tmo_mem_req", mem_req, 1'b0);
        check("tmo_busy", busy, 1'b0);
        check("tmo_reg_write", reg_write, 1'b0);
        check("tmo_done", done, 1'b0);
        tick;
        check("tmo_pulse_end", bus_err, 1'b0);
    endtask

    // gd/rvd: wait cycles before gnt/rvalid; a value >= TO means never.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rdi, input int gd,
                         input int rvd, input logic [31:0] rw);
        logic [3:0]  es;
        logic [31:0] ed;
        check("idle_ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        rd_in      = rdi;
        tick;
        scramble();
        if (is_fault(st, f3, a)) begin
            check("fault_misalign", misalign, 1'b1);
            check("fault_no_req", mem_req, 1'b0);
            check("fault_busy", busy, 1'b1);
            tick;
            req_valid = 1'b0;
            check("fault_pulse_end", misalign, 1'b0);
            check("fault_idle", busy, 1'b0);
            check("fault_no_wr", reg_write, 1'b0);
            return;
        end
        store_lanes(st, f3, a, sd, es, ed);
        for (int k = 0; k <= gd && k < int'(TO); k++) begin
            check("req_held", mem_req, 1'b1);
            check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("req_we", mem_we, st);
            check("req_wstrb", mem_wstrb, es);
            if (st) check("req_wdata", mem_wdata, ed);
            mem_gnt    = (k == gd);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            tick;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            scramble();
        end
        if (gd >= int'(TO)) begin
            expect_timeout();
            return;
        end
        if (st) begin
            check("st_done", done, 1'b1);
            check("st_no_wr", reg_write, 1'b0);
            tick;
            req_valid = 1'b0;
            check("st_done_end", done, 1'b0);
            check("st_idle", req_ready, 1'b1);
            return;
        end
        for (int k = 0; k <= rvd && k < int'(TO); k++) begin
            check("resp_no_req", mem_req, 1'b0);
            check("resp_busy", busy, 1'b1);
            mem_rvalid = (k == rvd);
            mem_rdata  = (k == rvd) ? rw : $urandom;
            mem_gnt    = 1'($urandom_range(0, 1));
            tick;
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b0;
            scramble();
        end
        if (rvd >= int'(TO)) begin
            expect_timeout();
            return;
        end
        check("ld_done", done, 1'b1);
        check("ld_reg_write", reg_write, rdi != 5'd0);
        check("ld_rd", rd, rdi);
        check("ld_data", write_data, load_value(f3, a, rw));
        tick;
        req_valid = 1'b0;
        check("ld_done_end", done, 1'b0);
        check("ld_wr_end", reg_write, 1'b0);
        check("ld_idle", req_ready, 1'b1);
    endtask

    task automatic reset_mid_op(input logic in_resp);
        req_valid  = 1'b1;
        is_store   = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h300;
        store_data = 32'h0;
        rd_in      = 5'd7;
        tick;
        req_valid = 1'b0;
        check("rst_pre_req", mem_req, 1'b1);
        if (in_resp) begin
            mem_gnt = 1'b1;
            tick;
            mem_gnt = 1'b0;
            check("rst_pre_resp", busy, 1'b1);
        end
        #2 reset = 1'b1;
        #1;
        check("rst_mid_req", mem_req, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", req_ready, 1'b1);
        #1 reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        tick;
        tick;
        check("stray_rv_wr", reg_write, 1'b0);
        check("stray_rv_done", done, 1'b0);
        check("stray_rv_busy", busy, 1'b0);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          gd, rvd;

        reset      = 1'b1;
        req_valid  = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        rd_in      = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #12;
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_wstrb", mem_wstrb, 4'h0);
        check("rst_reg_write", reg_write, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        reset = 1'b0;
        tick;

        do_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);
        do_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80FF_FFFF);
        do_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80FF_FFFF);
        do_op(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9, 0, 0, 32'h0);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd3, 0, 0, 32'h0);
        do_op(1'b1, 3'b100, 32'h200, 32'h0, 5'd3, 0, 0, 32'h0);
        do_op(1'b0, 3'b010, 32'h104, 32'h0, 5'd4, 0, TO, 32'h0);
        do_op(1'b1, 3'b010, 32'h108, 32'h5555_AAAA, 5'd4, TO, 0, 32'h0);
        do_op(1'b0, 3'b001, 32'h10A, 32'h0, 5'd8, TO - 1, TO - 1, 32'h8001_7FFF);
        reset_mid_op(1'b0);
        reset_mid_op(1'b1);
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd0, 0, 0, 32'h1234_5678);

        for (int i = 0; i < 300; i++) begin
            st  = 1'($urandom_range(0, 1));
            f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!st && $urandom_range(0, 1) == 1) f3 = f3 | 3'b100;
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            gd  = ($urandom_range(0, 7) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
            rvd = ($urandom_range(0, 7) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
            do_op(st, f3, a, $urandom, 5'($urandom), gd, rvd, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                mem_gnt    = 1'($urandom_range(0, 1));
                mem_rvalid = 1'($urandom_range(0, 1));
                tick;
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                check("gap_idle", busy, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
